// File: rtl/conf_int_pkg.sv
// Shared types and width helpers for the configurable-precision frame accumulator.
package conf_int_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    function automatic int acc_w(input int dpw, input int acc_len);
        return dpw + 1 + $clog2(acc_len);
    endfunction

    function automatic int cnt_w(input int acc_len);
        return $clog2(acc_len) + 1;
    endfunction

endpackage

// File: rtl/conf_int_trunc.sv
// Precision mask: clears the low DATA_PATH_BITWIDTH-OP_BITWIDTH bits of an adder sum.
module conf_int_trunc #(
    parameter int OP_BITWIDTH        = 16,
    parameter int DATA_PATH_BITWIDTH = 16
) (
    input  logic [DATA_PATH_BITWIDTH:0] in_data,
    output logic [DATA_PATH_BITWIDTH:0] out_data
);

    localparam int DROP = DATA_PATH_BITWIDTH - OP_BITWIDTH;
    localparam logic [DATA_PATH_BITWIDTH:0] KEEP = {(DATA_PATH_BITWIDTH+1){1'b1}} << DROP;

    assign out_data = in_data & KEEP;

endmodule

// File: rtl/conf_int_add_acc__ff.sv
// Frame accumulator: sums ACC_LEN precision-masked beats (or fewer on flush) and
// holds the registered sum and beat count until downstream takes it.
module conf_int_add_acc__ff
    import conf_int_pkg::*;
#(
    parameter int OP_BITWIDTH        = 16,
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int ACC_LEN            = 8,
    localparam int ACC_W             = acc_w(DATA_PATH_BITWIDTH, ACC_LEN),
    localparam int CNT_W             = cnt_w(ACC_LEN)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_PATH_BITWIDTH:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [ACC_W-1:0]            out_data,
    output logic [CNT_W-1:0]            out_count,
    output logic                        out_valid,
    input  logic                        out_ready
);

    state_e                      state_q, state_d;
    logic [ACC_W-1:0]            acc_q, acc_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [ACC_W-1:0]            out_data_q, out_data_d;
    logic [CNT_W-1:0]            out_count_q, out_count_d;
    logic                        out_valid_q, out_valid_d;

    logic [DATA_PATH_BITWIDTH:0] beat_masked;
    logic                        beat_take;
    logic                        frame_close;
    logic [ACC_W-1:0]            acc_sum;
    logic [CNT_W-1:0]            cnt_inc;

    conf_int_trunc #(
        .OP_BITWIDTH        (OP_BITWIDTH),
        .DATA_PATH_BITWIDTH (DATA_PATH_BITWIDTH)
    ) u_trunc (
        .in_data  (in_data),
        .out_data (beat_masked)
    );

    // in_ready is the only combinational output; HOLD refuses beats, so none
    // can slip in during the cycle the result transfers.
    assign in_ready = ~rst & (state_q != HOLD);

    // Next-state, accumulator and result-register update.
    always_comb begin
        beat_take   = in_valid & in_ready;
        acc_sum     = acc_q + ACC_W'(beat_masked);
        cnt_inc     = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        frame_close = 1'b0;
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (beat_take) begin
                    acc_d   = acc_sum;
                    count_d = cnt_inc;
                end else begin
                    acc_d   = acc_q;
                    count_d = count_q;
                end
                // A lone flush in IDLE has no frame to close.
                frame_close = (beat_take && (cnt_inc == CNT_W'(ACC_LEN)))
                            || (flush && (beat_take || (state_q == ACCUM)));
                if (frame_close) begin
                    state_d     = HOLD;
                    out_data_d  = acc_d;
                    out_count_d = count_d;
                    out_valid_d = 1'b1;
                    acc_d       = {ACC_W{1'b0}};
                    count_d     = {CNT_W{1'b0}};
                end else if (beat_take) begin
                    state_d = ACCUM;
                end else begin
                    state_d = state_q;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    acc_d       = {ACC_W{1'b0}};
                    count_d     = {CNT_W{1'b0}};
                    out_valid_d = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d     = IDLE;
                acc_d       = {ACC_W{1'b0}};
                count_d     = {CNT_W{1'b0}};
                out_valid_d = 1'b0;
            end
        endcase
    end

    // All state lives here; reset wins over any concurrent beat, flush or transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= {ACC_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            out_data_q  <= {ACC_W{1'b0}};
            out_count_q <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_conf_int_add_acc__ff.sv
// Bench for conf_int_add_acc__ff: full-precision and OP_BITWIDTH=12 instances share stimulus.
module tb_conf_int_add_acc__ff;

    localparam logic [16:0] MASK_B = 17'h1FFF0;  // 16-12 = 4 low bits dropped

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [16:0] in_data;
    logic        ir_a, ov_a, ir_b, ov_b;
    logic [19:0] od_a, od_b;
    logic [3:0]  oc_a, oc_b;
    logic        ir_pre_a, ir_pre_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conf_int_add_acc__ff dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_a),
        .flush(flush), .out_data(od_a), .out_count(oc_a), .out_valid(ov_a), .out_ready(out_ready)
    );

    conf_int_add_acc__ff #(.OP_BITWIDTH(12)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_b),
        .flush(flush), .out_data(od_b), .out_count(oc_b), .out_valid(ov_b), .out_ready(out_ready)
    );

    typedef struct {
        logic        r_rst, v;
        logic [16:0] d;
        logic        f, r;
        logic        e_ir, e_ov;
        logic [19:0] e_od;
        logic [3:0]  e_oc;
        logic        chk_d;
    } vec_t;

    vec_t tbl[18];
    int   nv = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r_rst, v, input logic [16:0] d, input logic f, r,
                       input logic e_ir, e_ov, input logic [19:0] e_od, input logic [3:0] e_oc,
                       input logic chk_d);
        tbl[nv] = '{r_rst, v, d, f, r, e_ir, e_ov, e_od, e_oc, chk_d};
        nv++;
    endtask

    // Drive one cycle; in_ready is sampled before the edge, outputs 1 time unit after.
    task automatic step(input logic r_rst, v, input logic [16:0] d, input logic f, r);
        rst = r_rst; in_valid = v; in_data = d; flush = f; out_ready = r;
        #1;
        ir_pre_a = ir_a;
        ir_pre_b = ir_b;
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain running sums, a holding flag and a held result.
    bit      m_hold;
    int      m_cnt, m_oc;
    longint  m_sum_a, m_sum_b, m_od_a, m_od_b;

    task automatic model_edge(input logic r_rst, v, input logic [16:0] d, input logic f, r);
        if (r_rst) begin
            m_hold = 0; m_cnt = 0; m_sum_a = 0; m_sum_b = 0;
        end else if (m_hold) begin
            if (r) m_hold = 0;
        end else begin
            if (v) begin
                m_sum_a += longint'(d);
                m_sum_b += longint'(d & MASK_B);
                m_cnt++;
            end
            if (m_cnt == 8 || (f && m_cnt > 0)) begin
                m_hold = 1; m_od_a = m_sum_a; m_od_b = m_sum_b; m_oc = m_cnt;
                m_sum_a = 0; m_sum_b = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic beats(input int n, input logic [16:0] d, input logic r, input string nm);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, d, 1'b0, r);
            chk($sformatf("%s_ir%0d", nm, i), 32'(ir_pre_a), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = 17'h0;

        // Table: reset, full frame of 1FFFE, refused beat on transfer, early flush, flush in IDLE.
        add(1, 0, 17'h0,     0, 0, 0, 0, 20'h0,     4'd0, 1);
        for (int i = 1; i <= 8; i++)
            add(0, 1, 17'h1FFFE, 0, 1, 1, (i == 8), (i == 8) ? 20'hFFFF0 : 20'h0,
                (i == 8) ? 4'd8 : 4'd0, (i == 8));
        add(0, 1, 17'h1FFFE, 0, 1, 0, 0, 20'h0,     4'd0, 0);
        add(0, 1, 17'h5,     0, 1, 1, 0, 20'h0,     4'd0, 0);
        add(0, 1, 17'h5,     0, 1, 1, 0, 20'h0,     4'd0, 0);
        add(0, 1, 17'h5,     1, 1, 1, 1, 20'd15,    4'd3, 1);
        add(0, 0, 17'h0,     1, 1, 0, 0, 20'h0,     4'd0, 0);
        add(0, 0, 17'h0,     1, 1, 1, 0, 20'h0,     4'd0, 0);
        add(0, 0, 17'h0,     0, 1, 1, 0, 20'h0,     4'd0, 0);
        add(0, 1, 17'h7,     1, 0, 1, 1, 20'd7,     4'd1, 1);
        add(0, 0, 17'h0,     0, 1, 0, 0, 20'h0,     4'd0, 0);

        for (int i = 0; i < nv; i++) begin
            step(tbl[i].r_rst, tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
            chk($sformatf("tbl%0d_in_ready", i), 32'(ir_pre_a), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_out_valid", i), 32'(ov_a), 32'(tbl[i].e_ov));
            if (tbl[i].chk_d) begin
                chk($sformatf("tbl%0d_out_data", i), 32'(od_a), 32'(tbl[i].e_od));
                chk($sformatf("tbl%0d_out_count", i), 32'(oc_a), 32'(tbl[i].e_oc));
            end
        end

        // Masking at OP_BITWIDTH=12.
        step(1'b1, 1'b0, 17'h0, 1'b0, 1'b0);
        beats(8, 17'h0000F, 1'b1, "mask0");
        chk("mask0_ov_b", 32'(ov_b), 32'd1);
        chk("mask0_od_b", 32'(od_b), 32'h0);
        chk("mask0_oc_b", 32'(oc_b), 32'd8);
        chk("mask0_od_a", 32'(od_a), 32'h78);
        step(1'b0, 1'b0, 17'h0, 1'b0, 1'b1);
        beats(8, 17'h10010, 1'b1, "mask1");
        chk("mask1_od_b", 32'(od_b), 32'h80080);
        chk("mask1_od_a", 32'(od_a), 32'h80080);
        step(1'b0, 1'b0, 17'h0, 1'b0, 1'b1);

        // Backpressure: held result stable for 5 cycles, offered beat waits.
        beats(8, 17'h3, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 17'h9, 1'b0, 1'b0);
            chk($sformatf("bp_hold%0d_ir", i), 32'(ir_pre_a), 32'd0);
            chk($sformatf("bp_hold%0d_ov", i), 32'(ov_a), 32'd1);
            chk($sformatf("bp_hold%0d_od", i), 32'(od_a), 32'd24);
            chk($sformatf("bp_hold%0d_oc", i), 32'(oc_a), 32'd8);
        end
        step(1'b0, 1'b1, 17'h9, 1'b0, 1'b1);
        chk("bp_release_ir", 32'(ir_pre_a), 32'd0);
        chk("bp_release_ov", 32'(ov_a), 32'd0);
        beats(8, 17'h9, 1'b1, "bp2");
        chk("bp2_od", 32'(od_a), 32'd72);
        chk("bp2_oc", 32'(oc_a), 32'd8);
        step(1'b0, 1'b0, 17'h0, 1'b0, 1'b1);

        // Reset mid-frame discards the partial sum.
        beats(4, 17'h2, 1'b1, "rmf");
        step(1'b1, 1'b1, 17'h2, 1'b1, 1'b1);
        chk("rmf_ir_in_rst", 32'(ir_pre_a), 32'd0);
        chk("rmf_ov", 32'(ov_a), 32'd0);
        chk("rmf_od", 32'(od_a), 32'd0);
        chk("rmf_oc", 32'(oc_a), 32'd0);
        beats(8, 17'h1, 1'b1, "rmf2");
        chk("rmf2_ov", 32'(ov_a), 32'd1);
        chk("rmf2_od", 32'(od_a), 32'd8);
        chk("rmf2_oc", 32'(oc_a), 32'd8);

        // Random traffic against the model.
        begin
            int          nbeats = 0;
            int          cyc = 0;
            logic        rr, vv, ff, oo, pred_ir;
            logic [16:0] dd;
            step(1'b1, 1'b0, 17'h0, 1'b0, 1'b0);
            model_edge(1'b1, 1'b0, 17'h0, 1'b0, 1'b0);
            while (nbeats < 10000 && cyc < 40000) begin
                rr = ($urandom_range(0, 1999) == 0);
                vv = ($urandom_range(0, 9) < 7);
                ff = ($urandom_range(0, 19) == 0);
                oo = ($urandom_range(0, 9) < 6);
                dd = 17'($urandom);
                pred_ir = !m_hold && !rr;
                if (vv && pred_ir) nbeats++;
                step(rr, vv, dd, ff, oo);
                chk("rnd_ir_a", 32'(ir_pre_a), 32'(pred_ir));
                chk("rnd_ir_b", 32'(ir_pre_b), 32'(pred_ir));
                model_edge(rr, vv, dd, ff, oo);
                chk("rnd_ov_a", 32'(ov_a), 32'(m_hold));
                chk("rnd_ov_b", 32'(ov_b), 32'(m_hold));
                if (m_hold) begin
                    chk("rnd_od_a", 32'(od_a), 32'(m_od_a));
                    chk("rnd_oc_a", 32'(oc_a), 32'(m_oc));
                    chk("rnd_od_b", 32'(od_b), 32'(m_od_b));
                    chk("rnd_oc_b", 32'(oc_b), 32'(m_oc));
                end
                cyc++;
            end
            chk("rnd_beat_budget", 32'(nbeats >= 10000), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
